// File: rtl/sig_divider_seq.sv
// rtl/sig_divider_seq.sv - multi-cycle restoring divider for normalized significands
//
// Computes Q = A/B for 1.NSIG significands, one quotient bit per clock, and
// presents a normalized quotient plus the exponent-adjust and sticky flags the
// rounding stage needs. One operation in flight; valid/ready on both sides.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (registered)
//   A          in   dividend significand, 1.xxx form, NSIG+1 bits
//   B          in   divisor significand, 1.xxx form, NSIG+1 bits
//   out_valid  out  result valid (registered)
//   out_ready  in   downstream accepts the result
//   Q          out  normalized quotient, 1.xxx form, NSIG+1 bits
//   exp_adj    out  1: A<B, quotient shifted left by one; caller decrements exponent
//   sticky     out  OR of discarded quotient bits and nonzero remainder
//   dz         out  divide by zero (B hidden bit clear)

module sig_divider_seq #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NSIG:0]   A,
  input  logic [NSIG:0]   B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NSIG:0]   Q,
  output logic            exp_adj,
  output logic            sticky,
  output logic            dz
);

  localparam int SW    = NSIG + 1;  // significand width
  localparam int RW    = NSIG + 2;  // remainder / raw quotient width
  localparam int CNT_W = $clog2(NSIG + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSIG + 1);

  // NEXP only travels alongside the significand in the FPU; reject nonsense
  // parameterisations at elaboration time.
  if (NEXP < 1 || NSIG < 1) begin : g_bad_params
    $error("sig_divider_seq: NEXP and NSIG must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     b_q, b_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [RW-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     res_q, res_d;
  logic              exp_adj_q, exp_adj_d;
  logic              sticky_q, sticky_d;
  logic              dz_q, dz_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  // One restoring step, evaluated every cycle and used only in CALC.
  logic              ge;
  logic [RW-1:0]     rem_diff;
  logic [RW-1:0]     rem_next;
  logic [RW-1:0]     quo_next;

  always_comb begin
    ge       = (rem_q >= {1'b0, b_q});
    rem_diff = ge ? (rem_q - {1'b0, b_q}) : rem_q;
    // rem_diff < B, so doubling it never loses a set bit.
    rem_next = rem_diff << 1;
    quo_next = {quo_q[RW-2:0], ge};
  end

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    exp_adj_d   = exp_adj_q;
    sticky_d    = sticky_q;
    dz_d        = dz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (B[NSIG]) begin
            b_d     = B;
            rem_d   = {1'b0, A};
            quo_d   = '0;
            cnt_d   = '0;
            state_d = ST_CALC;
          end else begin
            res_d       = '1;
            dz_d        = 1'b1;
            exp_adj_d   = 1'b0;
            sticky_d    = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end

      ST_CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Integer bit of the raw quotient set means A>=B: drop the lowest
          // bit into sticky. Otherwise the quotient is already one place low.
          if (quo_next[RW-1]) begin
            res_d     = quo_next[RW-1:1];
            exp_adj_d = 1'b0;
            sticky_d  = quo_next[0] | (|rem_next);
          end else begin
            res_d     = quo_next[SW-1:0];
            exp_adj_d = 1'b1;
            sticky_d  = |rem_next;
          end
          dz_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      exp_adj_q   <= 1'b0;
      sticky_q    <= 1'b0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      exp_adj_q   <= exp_adj_d;
      sticky_q    <= sticky_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = res_q;
  assign exp_adj   = exp_adj_q;
  assign sticky    = sticky_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_sig_divider_seq.sv
// tb/tb_sig_divider_seq.sv - directed self-checking bench for sig_divider_seq

module tb_sig_divider_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Q;
  logic       exp_adj;
  logic       sticky;
  logic       dz;

  int errors = 0;
  int checks = 0;

  sig_divider_seq #(.NEXP(8), .NSIG(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .exp_adj   (exp_adj),
    .sticky    (sticky),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result, check it, then complete the
  // output handshake. lat_exp counts clocks after the accepting edge until
  // out_valid is seen; the divide-by-zero result is already up after that edge.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] q_exp, input logic adj_exp,
                       input logic st_exp, input logic dz_exp,
                       input int lat_exp, input string name);
    int lat;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready_pre: got %b, required 1", name, in_ready);
    end
    in_valid = 1'b1;
    A = a;
    B = b;
    tick();
    in_valid = 1'b0;
    A = 8'h5A;
    B = 8'h00;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== lat_exp) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, lat_exp);
    end
    checks++;
    if (Q !== q_exp) begin
      errors++;
      $display("FAIL %s_Q: got %h, required %h", name, Q, q_exp);
    end
    checks++;
    if (exp_adj !== adj_exp) begin
      errors++;
      $display("FAIL %s_exp_adj: got %b, required %b", name, exp_adj, adj_exp);
    end
    checks++;
    if (sticky !== st_exp) begin
      errors++;
      $display("FAIL %s_sticky: got %b, required %b", name, sticky, st_exp);
    end
    checks++;
    if (dz !== dz_exp) begin
      errors++;
      $display("FAIL %s_dz: got %b, required %b", name, dz, dz_exp);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_in_ready_busy: got %b, required 0", name, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: got out_valid=%b in_ready=%b, required 0 1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic check_idle_cleared(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_hs: got in_ready=%b out_valid=%b, required 1 0",
               name, in_ready, out_valid);
    end
    checks++;
    if (Q !== 8'h00 || exp_adj !== 1'b0 || sticky !== 1'b0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL %s_outputs: got Q=%h exp_adj=%b sticky=%b dz=%b, required all 0",
               name, Q, exp_adj, sticky, dz);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = 8'h00;
    B = 8'h00;
    tick();
    tick();
    check_idle_cleared("reset");
    rst_n = 1'b1;
    tick();
    check_idle_cleared("reset_release");
  endtask

  task automatic test_divide();
    do_op(8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 9, "div_80_80");
    do_op(8'h80, 8'hC0, 8'hAA, 1'b1, 1'b1, 1'b0, 9, "div_80_c0");
    do_op(8'hFF, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0, 9, "div_ff_80");
    do_op(8'h80, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 9, "div_80_ff");
    // 0xC0/0xA0 = 1.2 -> 1.0011001(1...) : A>=B, sticky from dropped bits
    do_op(8'hC0, 8'hA0, 8'h99, 1'b0, 1'b1, 1'b0, 9, "div_c0_a0");
  endtask

  task automatic test_div_zero();
    do_op(8'h80, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 0, "dz_b00");
    do_op(8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 9, "dz_recover");
  endtask

  task automatic test_hold();
    int lat;
    in_valid = 1'b1;
    A = 8'h80;
    B = 8'hC0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL hold_latency: got %0d, required 9", lat);
    end
    // Offer a divide-by-zero while stalled; it must be ignored.
    in_valid = 1'b1;
    A = 8'hFF;
    B = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Q !== 8'hAA ||
          exp_adj !== 1'b1 || sticky !== 1'b1 || dz !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got ov=%b ir=%b Q=%h adj=%b st=%b dz=%b, required 1 0 aa 1 1 0",
                 i, out_valid, in_ready, Q, exp_adj, sticky, dz);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got out_valid=%b in_ready=%b, required 0 1",
               out_valid, in_ready);
    end
    do_op(8'hFF, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0, 9, "after_hold");
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    A = 8'h80;
    B = 8'hC0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    // Now inside the 4th CALC cycle.
    rst_n = 1'b0;
    tick();
    check_idle_cleared("reset_mid");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_result%0d: got out_valid=%b, required 0", i, out_valid);
      end
    end
    do_op(8'h80, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 9, "after_reset");
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
